// File: rtl/group3_stepper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : group3_stepper_pkg
//  Description : Shared types and constants for the stepper phase sequencer:
//                FSM state enum, the 8-entry coil phase table and the
//                half/full step index increments.
//  Revision    : 1.0  initial release
// ============================================================================
package group3_stepper_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Coil patterns {A,B,C,D} packed with idx 0 in the low nibble.
    // idx: 7=1001 6=0001 5=0011 4=0010 3=0110 2=0100 1=1100 0=1000
    localparam logic [31:0] PHASE_TABLE = 32'h9132_64C8;

    // Index increments. Full steps move by 2 so idx parity is preserved:
    // even idx gives one-coil drive, odd idx gives two-coil drive.
    localparam logic [2:0] HALF_STEP = 3'd1;
    localparam logic [2:0] FULL_STEP = 3'd2;

    function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
        return PHASE_TABLE[{idx, 2'b00} +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/group3_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : group3_edge_sync
//  Description : Multi-flop synchronizer for an asynchronous input followed
//                by a rising-edge detector. TICK is high for one clk cycle,
//                SYNC_STAGES cycles after the input rise is first sampled.
//  Ports       : clk      - system clock
//                rst      - synchronous active-high reset
//                async_in - asynchronous level input
//                tick     - single-cycle rising-edge pulse
//  Revision    : 1.0  initial release
// ============================================================================
module group3_edge_sync #(
    parameter int SYNC_STAGES = 2   // must be at least 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   last_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_chain <= '0;
            last_level <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_in};
            last_level <= sync_chain[SYNC_STAGES-1];
        end
    end

    // Combinational from two flops so the pulse lands in the cycle right
    // after the last synchronizer stage captures the new level.
    assign tick = sync_chain[SYNC_STAGES-1] & ~last_level;

endmodule
`default_nettype wire

// File: rtl/group3_stepper_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : group3_stepper_sequencer
//  Description : Stepper-motor coil phase sequencer. Each rising edge of the
//                divided STEP_IN clock advances the phase index by a half or
//                full step while a move is running. Moves are launched with a
//                START/BUSY/DONE handshake and a signed position is kept.
//  Ports       : CLK, RST       - clock, synchronous active-high reset
//                STEP_IN        - asynchronous step clock
//                EN             - coil enable / step pause
//                START, STOP    - move request (IDLE only), abort (RUN only)
//                DIR, HALF      - direction and step mode, latched at START
//                STEPS          - move length, latched at START
//                PHASE          - registered coil pattern {A,B,C,D}
//                POS            - two's-complement position in steps
//                BUSY, DONE     - move in progress, end-of-move pulse
//  Revision    : 1.0  initial release
// ============================================================================
module group3_stepper_sequencer
    import group3_stepper_pkg::*;
#(
    parameter int STEP_W      = 16,
    parameter int POS_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              STEP_IN,
    input  logic              EN,
    input  logic              START,
    input  logic              STOP,
    input  logic              DIR,
    input  logic              HALF,
    input  logic [STEP_W-1:0] STEPS,
    output logic [3:0]        PHASE,
    output logic [POS_W-1:0]  POS,
    output logic              BUSY,
    output logic              DONE
);

    state_t            state;
    logic [2:0]        idx;
    logic [STEP_W-1:0] rem;
    logic              move_dir;
    logic              move_half;
    logic              tick;
    logic [2:0]        step_size;

    group3_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_step_sync (
        .clk      (CLK),
        .rst      (RST),
        .async_in (STEP_IN),
        .tick     (tick)
    );

    assign step_size = move_half ? HALF_STEP : FULL_STEP;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            idx       <= 3'd0;
            rem       <= '0;
            move_dir  <= 1'b0;
            move_half <= 1'b0;
            PHASE     <= 4'b0000;
            POS       <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            DONE  <= 1'b0;
            // PHASE trails idx by one cycle; idx itself only moves in RUN.
            PHASE <= EN ? phase_pattern(idx) : 4'b0000;

            case (state)
                IDLE: begin
                    if (START) begin
                        move_dir  <= DIR;
                        move_half <= HALF;
                        rem       <= STEPS;
                        if (STEPS == '0) begin
                            state <= FINISH;
                            DONE  <= 1'b1;
                        end else begin
                            state <= RUN;
                            BUSY  <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    // STOP has priority over a coincident tick.
                    if (STOP) begin
                        state <= FINISH;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end else if (EN && tick) begin
                        idx <= move_dir ? (idx + step_size) : (idx - step_size);
                        POS <= move_dir ? (POS + POS_W'(1)) : (POS - POS_W'(1));
                        rem <= rem - STEP_W'(1);
                        if (rem == STEP_W'(1)) begin
                            state <= FINISH;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_group3_stepper_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_group3_stepper_sequencer
//  Description : Scoreboard bench. Stimulus tasks advance a reference model
//                (phase index mod 8, position mod 2^POS_W) and push the
//                expected step and end-of-move results into queues; a monitor
//                pops them whenever POS moves or DONE pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_group3_stepper_sequencer;

    localparam int STEP_W      = 16;
    localparam int POS_W       = 8;   // narrow so the wrap case is reachable quickly
    localparam int SYNC_STAGES = 2;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              STEP_IN = 1'b0;
    logic              EN = 1'b1;
    logic              START = 1'b0;
    logic              STOP = 1'b0;
    logic              DIR = 1'b0;
    logic              HALF = 1'b0;
    logic [STEP_W-1:0] STEPS = '0;
    logic [3:0]        PHASE;
    logic [POS_W-1:0]  POS;
    logic              BUSY;
    logic              DONE;

    group3_stepper_sequencer #(
        .STEP_W      (STEP_W),
        .POS_W       (POS_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .STEP_IN (STEP_IN),
        .EN      (EN),
        .START   (START),
        .STOP    (STOP),
        .DIR     (DIR),
        .HALF    (HALF),
        .STEPS   (STEPS),
        .PHASE   (PHASE),
        .POS     (POS),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [3:0]       tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                  4'b0010, 4'b0011, 4'b0001, 4'b1001};
    int               m_idx  = 0;
    logic [POS_W-1:0] m_pos  = '0;
    int               m_rem  = 0;
    bit               m_dir, m_half;

    logic [POS_W-1:0] step_pos_q [$];
    logic [3:0]       step_phase_q [$];
    logic [POS_W-1:0] done_pos_q [$];

    task automatic model_step();
        int delta;
        delta = m_half ? 1 : 2;
        if (!m_dir) delta = -delta;
        m_idx = ((m_idx + delta) % 8 + 8) % 8;
        m_pos = m_dir ? m_pos + 1'b1 : m_pos - 1'b1;
        m_rem--;
        step_pos_q.push_back(m_pos);
        step_phase_q.push_back(tbl[m_idx]);
        if (m_rem == 0) done_pos_q.push_back(m_pos);
    endtask

    // ---------------- monitor ----------------
    logic [POS_W-1:0] last_pos   = '0;
    logic [3:0]       cur_phase  = 4'b1000;
    logic [3:0]       pend_phase = 4'b0000;
    bit               pend_valid = 0;
    bit               rst_prev   = 1;
    bit               en_prev    = 1;

    always @(negedge CLK) begin
        if (RST) begin
            last_pos   = '0;
            cur_phase  = 4'b1000;
            pend_valid = 0;
        end else begin
            if (pend_valid) begin
                cur_phase  = pend_phase;
                pend_valid = 0;
            end
            if (!rst_prev) begin
                if (en_prev) chk("phase", {28'd0, PHASE}, {28'd0, cur_phase});
                else         chk("phase_off", {28'd0, PHASE}, 32'd0);
            end
            if (POS !== last_pos) begin
                if (step_pos_q.size() == 0) begin
                    chk("unexpected_step", {24'd0, POS}, {24'd0, last_pos});
                end else begin
                    chk("step_pos", {24'd0, POS}, {24'd0, step_pos_q.pop_front()});
                    pend_phase = step_phase_q.pop_front();
                    pend_valid = 1;
                end
                last_pos = POS;
            end
            if (DONE === 1'b1) begin
                if (done_pos_q.size() == 0) chk("unexpected_done", {31'd0, DONE}, 32'd0);
                else chk("done_pos", {24'd0, POS}, {24'd0, done_pos_q.pop_front()});
                chk("busy_at_done", {31'd0, BUSY}, 32'd0);
            end
        end
        rst_prev = RST;
        en_prev  = EN;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic step_pulse(input bit counts);
        STEP_IN = 1'b1;
        if (counts) model_step();
        cyc(4);
        STEP_IN = 1'b0;
        cyc(4);
    endtask

    task automatic run_move(input bit dir, input bit half, input int steps,
                            input int pause_at, input int stop_at);
        m_dir  = dir;
        m_half = half;
        m_rem  = steps;
        START  = 1'b1; DIR = dir; HALF = half; STEPS = STEP_W'(steps);
        if (steps == 0) done_pos_q.push_back(m_pos);
        cyc(1);
        START  = 1'b0;
        chk("busy_after_start", {31'd0, BUSY}, (steps != 0) ? 32'd1 : 32'd0);
        chk("done_after_start", {31'd0, DONE}, (steps == 0) ? 32'd1 : 32'd0);
        for (int k = 0; k < steps; k++) begin
            if (k == pause_at) begin
                EN = 1'b0;
                cyc(2);
                repeat (3) step_pulse(0);
                chk("pos_frozen", {24'd0, POS}, {24'd0, m_pos});
                chk("busy_paused", {31'd0, BUSY}, 32'd1);
                EN = 1'b1;
                cyc(2);
            end
            if (k == stop_at) begin
                // Align STOP with the cycle the synchronized edge ticks.
                STEP_IN = 1'b1;
                cyc(2);
                done_pos_q.push_back(m_pos);
                STOP = 1'b1;
                cyc(1);
                STOP = 1'b0;
                chk("busy_after_stop", {31'd0, BUSY}, 32'd0);
                chk("done_after_stop", {31'd0, DONE}, 32'd1);
                cyc(3);
                STEP_IN = 1'b0;
                cyc(4);
                break;
            end
            step_pulse(1);
        end
        cyc(2);
        chk("busy_end", {31'd0, BUSY}, 32'd0);
        chk("pos_end", {24'd0, POS}, {24'd0, m_pos});
    endtask

    initial begin
        int st, pa, sp;
        logic [POS_W-1:0] need;

        // Reset with EN high and no move requested.
        cyc(3);
        chk("rst_phase", {28'd0, PHASE}, 32'd0);
        chk("rst_pos", {24'd0, POS}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        RST = 1'b0;
        cyc(1);
        chk("phase_after_rst", {28'd0, PHASE}, 32'h8);
        repeat (3) step_pulse(0);
        chk("idle_pos", {24'd0, POS}, 32'd0);

        run_move(1'b1, 1'b0, 4, -1, -1);   // forward full: 0100 0010 0001 1000
        chk("fwd_full_pos", {24'd0, POS}, 32'd4);
        run_move(1'b0, 1'b1, 3, -1, -1);   // reverse half: 1001 0001 0011
        run_move(1'b1, 1'b0, 0, -1, -1);   // zero-length move
        run_move(1'b1, 1'b1, 5, -1, 2);    // STOP on a tick
        run_move(1'b0, 1'b0, 6, 3, -1);    // EN pause for 3 ticks

        for (int r = 0; r < 10; r++) begin
            st = $urandom_range(1, 10);
            pa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, st - 1) : -1;
            sp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, st - 1) : -1;
            run_move($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, st, pa, sp);
        end

        // Position wrap from the positive maximum to the negative minimum.
        need = 8'h7F - m_pos;
        if (need != 0) run_move(1'b1, 1'b0, int'(need), -1, -1);
        chk("pos_max", {24'd0, POS}, 32'h7F);
        run_move(1'b1, 1'b1, 1, -1, -1);
        chk("pos_wrap", {24'd0, POS}, 32'h80);

        // Reset in the middle of a move: no DONE, everything back to zero.
        m_dir = 1'b1; m_half = 1'b1; m_rem = 5;
        START = 1'b1; DIR = 1'b1; HALF = 1'b1; STEPS = 16'd5;
        cyc(1);
        START = 1'b0;
        step_pulse(1);
        RST = 1'b1;
        cyc(1);
        chk("midrst_phase", {28'd0, PHASE}, 32'd0);
        chk("midrst_pos", {24'd0, POS}, 32'd0);
        chk("midrst_busy", {31'd0, BUSY}, 32'd0);
        chk("midrst_done", {31'd0, DONE}, 32'd0);
        m_pos = '0;
        m_idx = 0;
        RST = 1'b0;
        cyc(2);
        run_move(1'b1, 1'b1, 2, -1, -1);

        cyc(10);
        chk("step_q_empty", step_pos_q.size(), 32'd0);
        chk("done_q_empty", done_pos_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
